// File: rtl/clk_step_if.sv
// Command channel between a debug host and the run/halt/step controller.
// The host (master) presents an opcode and argument with cmd_valid; the
// controller (slave) accepts it on any cycle where cmd_ready is also high.
interface clk_step_if #(
  parameter int CNT_W = 32
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller for the clk_en pin of a clock-enabled
// datapath. Takes HALT / RUN / STEP N / SET_BP commands from a host,
// stops a free run when the observed datapath value hits an armed
// breakpoint, and counts every enabled cycle for debug and state capture.
// CNT_W must be larger than BP_W so SET_BP can carry value plus enable bit.
module clk_step_ctrl #(
  parameter int CNT_W = 32,
  parameter int BP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  clk_step_if.slave        cmd,
  input  logic [BP_W-1:0]  dut_value,
  output logic             clk_en,
  output logic             halted,
  output logic             step_done,
  output logic             bp_hit,
  output logic             cmd_err,
  output logic [CNT_W-1:0] cycles_run
);

  localparam logic [1:0] ST_HALTED   = 2'd0;
  localparam logic [1:0] ST_RUNNING  = 2'd1;
  localparam logic [1:0] ST_STEPPING = 2'd2;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic             run_first;
  logic             run_first_nxt;
  logic             step_done_nxt;
  logic             bp_hit_nxt;
  logic             cmd_err_nxt;

  logic             bp_en;
  logic [BP_W-1:0]  bp_val;

  logic             accept;
  logic             is_halt;
  logic             is_run;
  logic             is_step;
  logic             is_set_bp;
  logic             bp_match;
  logic             step_last;
  logic             enabled_nxt;

  // The controller can take a command every cycle except while held in reset.
  assign cmd.cmd_ready = ~rst;

  assign accept    = cmd.cmd_valid & ~rst;
  assign is_halt   = accept && (cmd.cmd_op == OP_HALT);
  assign is_run    = accept && (cmd.cmd_op == OP_RUN);
  assign is_step   = accept && (cmd.cmd_op == OP_STEP);
  assign is_set_bp = accept && (cmd.cmd_op == OP_SET_BP);

  // The first RUNNING cycle after a RUN is masked so that a run resumed while
  // the datapath still sits on the breakpoint value does not stop at once.
  assign bp_match  = (state == ST_RUNNING) && bp_en && !run_first &&
                     (dut_value == bp_val);
  assign step_last = (state == ST_STEPPING) && (remaining == CNT_W'(1));

  assign enabled_nxt = (state_nxt == ST_RUNNING) || (state_nxt == ST_STEPPING);

  // Next-state decode; stop sources are ordered HALT > breakpoint > step end.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    run_first_nxt = 1'b0;
    step_done_nxt = 1'b0;
    bp_hit_nxt    = 1'b0;
    cmd_err_nxt   = 1'b0;

    if (state == ST_STEPPING) begin
      remaining_nxt = remaining - CNT_W'(1);
    end

    if (is_halt) begin
      state_nxt     = ST_HALTED;
      remaining_nxt = '0;
      bp_hit_nxt    = bp_match;
    end else if (bp_match) begin
      state_nxt  = ST_HALTED;
      bp_hit_nxt = 1'b1;
    end else if (step_last) begin
      state_nxt     = ST_HALTED;
      step_done_nxt = 1'b1;
    end

    // RUN and STEP only start from HALTED, which the stop sources above never
    // share, so these branches cannot collide with a stop in the same cycle.
    if (is_run) begin
      if (state == ST_HALTED) begin
        state_nxt     = ST_RUNNING;
        run_first_nxt = 1'b1;
      end else begin
        cmd_err_nxt = 1'b1;
      end
    end

    if (is_step) begin
      if (state == ST_HALTED) begin
        if (cmd.cmd_arg != '0) begin
          state_nxt     = ST_STEPPING;
          remaining_nxt = cmd.cmd_arg;
        end else begin
          step_done_nxt = 1'b1;
        end
      end else begin
        cmd_err_nxt = 1'b1;
      end
    end
  end

  // State register; clk_en and halted are flops so the enable is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HALTED;
      remaining <= '0;
      run_first <= 1'b0;
      clk_en    <= 1'b0;
      halted    <= 1'b1;
      step_done <= 1'b0;
      bp_hit    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      run_first <= run_first_nxt;
      clk_en    <= enabled_nxt;
      halted    <= (state_nxt == ST_HALTED);
      step_done <= step_done_nxt;
      bp_hit    <= bp_hit_nxt;
      cmd_err   <= cmd_err_nxt;
    end
  end

  // Breakpoint registers, writable in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_en  <= 1'b0;
      bp_val <= '0;
    end else if (is_set_bp) begin
      bp_en  <= cmd.cmd_arg[BP_W];
      bp_val <= cmd.cmd_arg[BP_W-1:0];
    end
  end

  // Enabled-cycle counter; wraps freely and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_run <= '0;
    end else if (clk_en) begin
      cycles_run <= cycles_run + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: a full-width controller driving a model 8-bit
// counter, plus a narrow CNT_W=4 instance for counter wrap-around.
module tb_clk_step_ctrl;

  localparam int CNT_W = 32;
  localparam int BP_W  = 8;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  clk_step_if #(.CNT_W(CNT_W)) cif ();
  logic [BP_W-1:0]  dut_value;
  logic             clk_en, halted, step_done, bp_hit, cmd_err;
  logic [CNT_W-1:0] cycles_run;

  clk_step_ctrl #(.CNT_W(CNT_W), .BP_W(BP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cif),
    .dut_value  (dut_value),
    .clk_en     (clk_en),
    .halted     (halted),
    .step_done  (step_done),
    .bp_hit     (bp_hit),
    .cmd_err    (cmd_err),
    .cycles_run (cycles_run)
  );

  // Narrow instance for wrap-around
  clk_step_if #(.CNT_W(4)) cif2 ();
  logic [1:0] dv2;
  logic       en2, h2, sd2, bh2, ce2;
  logic [3:0] cr2;
  assign dv2 = 2'd3;

  clk_step_ctrl #(.CNT_W(4), .BP_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cif2),
    .dut_value  (dv2),
    .clk_en     (en2),
    .halted     (h2),
    .step_done  (sd2),
    .bp_hit     (bh2),
    .cmd_err    (ce2),
    .cycles_run (cr2)
  );

  // Controlled datapath: 8-bit counter advancing only on enabled cycles.
  logic [7:0] count_out;
  logic       hold;
  logic [7:0] hold_val;
  always @(posedge clk) begin
    if (rst) count_out <= 8'd0;
    else if (clk_en) count_out <= count_out + 8'd1;
  end
  assign dut_value = hold ? hold_val : count_out;

  // Running totals of enabled cycles and pulses, used as before/after deltas.
  int en_tot = 0;
  int sd_tot = 0;
  int bp_tot = 0;
  int er_tot = 0;
  always @(posedge clk) begin
    if (clk_en)    en_tot <= en_tot + 1;
    if (step_done) sd_tot <= sd_tot + 1;
    if (bp_hit)    bp_tot <= bp_tot + 1;
    if (cmd_err)   er_tot <= er_tot + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] arg);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic issue2(input logic [1:0] op, input logic [3:0] arg);
    cif2.cmd_valid = 1'b1;
    cif2.cmd_op    = op;
    cif2.cmd_arg   = arg;
    @(posedge clk);
    #1;
    cif2.cmd_valid = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int bound);
    int k;
    k = 0;
    while (!halted && k < bound) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s0, b0, r0, n, m, k;
    logic [31:0] c0;
    logic [7:0]  cnt0, bp;
    int step_list [3];

    rst = 1'b1;
    hold = 1'b0;
    hold_val = 8'd0;
    cif.cmd_valid = 1'b0;  cif.cmd_op = 2'b00;  cif.cmd_arg = '0;
    cif2.cmd_valid = 1'b0; cif2.cmd_op = 2'b00; cif2.cmd_arg = '0;
    tick(3);

    // Reset state
    chk("rst_ready",  32'(cif.cmd_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_cycles", cycles_run, 32'd0);
    chk("rst_pulses", 32'({step_done, bp_hit, cmd_err}), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", 32'(cif.cmd_ready), 32'd1);

    // STEP N: exactly N enabled cycles, one step_done
    step_list[0] = 5;
    step_list[1] = int'($urandom_range(1, 20));
    step_list[2] = int'($urandom_range(1, 40));
    foreach (step_list[i]) begin
      n = step_list[i];
      e0 = en_tot; s0 = sd_tot; c0 = cycles_run; cnt0 = count_out;
      issue(OP_STEP, 32'(n));
      chk("step_en_on", 32'(clk_en), 32'd1);
      wait_halted("step_halt", n + 5);
      chk("step_done_pulse", 32'(step_done), 32'd1);
      tick(2);
      chk("step_en_cycles", 32'(en_tot - e0), 32'(n));
      chk("step_done_count", 32'(sd_tot - s0), 32'd1);
      chk("step_cycles_run", cycles_run - c0, 32'(n));
      chk("step_count_out", 32'(count_out), 32'(cnt0 + 8'(n)));
    end

    // Breakpoint at 0x2A, counter free-running from its current value
    bp = 8'h2A;
    issue(OP_SET_BP, 32'h12A);
    e0 = en_tot; b0 = bp_tot; cnt0 = count_out;
    k = int'(8'(bp - cnt0 - 8'd1)) + 1;
    issue(OP_RUN, 32'd0);
    wait_halted("bp_halt", 300);
    chk("bp_hit_pulse", 32'(bp_hit), 32'd1);
    chk("bp_clk_en_off", 32'(clk_en), 32'd0);
    chk("bp_count_out", 32'(count_out), 32'(bp + 8'd1));
    tick(2);
    chk("bp_en_cycles", 32'(en_tot - e0), 32'(k + 1));
    chk("bp_hit_count", 32'(bp_tot - b0), 32'd1);

    // Resume from the breakpoint stop, run a random length, then HALT
    m = int'($urandom_range(5, 100));
    e0 = en_tot; b0 = bp_tot;
    issue(OP_RUN, 32'd0);
    tick(m);
    chk("resume_running", 32'(halted), 32'd0);
    issue(OP_HALT, 32'd0);
    chk("halt_clk_en_off", 32'(clk_en), 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);
    tick(2);
    chk("resume_en_cycles", 32'(en_tot - e0), 32'(m + 1));
    chk("resume_no_bp", 32'(bp_tot - b0), 32'd0);

    // Datapath parked on the breakpoint value: first cycle masked, second stops
    hold = 1'b1;
    hold_val = bp;
    e0 = en_tot;
    issue(OP_RUN, 32'd0);
    chk("mask_first", 32'(halted), 32'd0);
    tick(1);
    chk("mask_second", 32'(halted), 32'd0);
    tick(1);
    chk("mask_stop", 32'(halted), 32'd1);
    chk("mask_bp_hit", 32'(bp_hit), 32'd1);
    chk("mask_en_cycles", 32'(en_tot - e0), 32'd2);

    // HALT and breakpoint in the same cycle: bp_hit still reported
    issue(OP_RUN, 32'd0);
    tick(1);
    issue(OP_HALT, 32'd0);
    chk("halt_bp_halted", 32'(halted), 32'd1);
    chk("halt_bp_hit", 32'(bp_hit), 32'd1);
    hold = 1'b0;
    tick(1);

    // Rejected RUN/STEP while running
    issue(OP_SET_BP, 32'd0);
    r0 = er_tot;
    issue(OP_RUN, 32'd0);
    issue(OP_STEP, 32'd3);
    chk("err_step", 32'(cmd_err), 32'd1);
    issue(OP_RUN, 32'd0);
    chk("err_run", 32'(cmd_err), 32'd1);
    chk("err_still_running", 32'(halted), 32'd0);
    tick(1);
    chk("err_pulse_ends", 32'(cmd_err), 32'd0);
    tick(1);
    chk("err_count", 32'(er_tot - r0), 32'd2);
    issue(OP_HALT, 32'd0);

    // STEP 0 while halted
    issue(OP_STEP, 32'd0);
    chk("step0_done", 32'(step_done), 32'd1);
    chk("step0_clk_en", 32'(clk_en), 32'd0);
    tick(1);
    chk("step0_pulse_ends", 32'(step_done), 32'd0);

    // Reset on the 4th enabled cycle of STEP 10 clears counter and breakpoint
    issue(OP_SET_BP, 32'h155);
    issue(OP_STEP, 32'd10);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_clk_en", 32'(clk_en), 32'd0);
    chk("rst_mid_cycles", cycles_run, 32'd0);
    chk("rst_mid_halted", 32'(halted), 32'd1);
    rst = 1'b0;
    hold = 1'b1;
    hold_val = 8'h55;
    b0 = bp_tot;
    issue(OP_RUN, 32'd0);
    tick(4);
    chk("rst_bp_disarmed", 32'(halted), 32'd0);
    chk("rst_bp_no_hit", 32'(bp_tot - b0), 32'd0);
    issue(OP_HALT, 32'd0);
    hold = 1'b0;

    // HALT on the final cycle of STEP 4: four enabled cycles, no step_done
    e0 = en_tot; s0 = sd_tot;
    issue(OP_STEP, 32'd4);
    tick(3);
    issue(OP_HALT, 32'd0);
    chk("halt_last_halted", 32'(halted), 32'd1);
    chk("halt_last_no_done", 32'(step_done), 32'd0);
    tick(2);
    chk("halt_last_en", 32'(en_tot - e0), 32'd4);
    chk("halt_last_sd", 32'(sd_tot - s0), 32'd0);

    // Narrow counter wraps 15 -> 0
    issue2(OP_STEP, 4'd15);
    k = 0;
    while (!h2 && k < 30) begin
      tick(1);
      k++;
    end
    chk("wrap_halt", 32'(h2), 32'd1);
    chk("wrap_sd", 32'(sd2), 32'd1);
    chk("wrap_15", 32'(cr2), 32'd15);
    issue2(OP_STEP, 4'd2);
    chk("wrap_still_15", 32'(cr2), 32'd15);
    tick(1);
    chk("wrap_0", 32'(cr2), 32'd0);
    tick(1);
    chk("wrap_1", 32'(cr2), 32'd1);
    chk("wrap_flags", 32'({h2, bh2, ce2, en2, cif2.cmd_ready}), 32'b10001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
